// File: rtl/iir_allpole_inverse.sv
// iir_allpole_inverse: all-pole IIR 1/A(z) in Q1.15.
// One shared multiplier walks the 7 feedback taps, one per clock.
module iir_allpole_inverse #(
   parameter logic signed [15:0] A1    = 16'shC000,
   parameter logic signed [15:0] A2    = 16'sh0000,
   parameter logic signed [15:0] A3    = 16'sh0000,
   parameter logic signed [15:0] A4    = 16'sh0000,
   parameter logic signed [15:0] A5    = 16'sh0000,
   parameter logic signed [15:0] A6    = 16'sh0000,
   parameter logic signed [15:0] A7    = 16'sh0000,
   parameter int                 ACC_W = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] data_out,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_RESULT,
      S_OUT
   } state_t;

   state_t state_q, state_d;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [2:0]              k_q, k_d;
   logic signed [15:0]      hist_q [1:7];
   logic signed [15:0]      hist_d [1:7];
   logic [15:0]             dout_q, dout_d;
   logic                    ov_q, ov_d;

   logic signed [15:0]      coef;
   logic signed [15:0]      hsel;
   logic signed [31:0]      prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] load;
   logic [ACC_W-31:0]       hi;
   logic [15:0]             sat;

   assign in_ready = reset & (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign out_valid = ov_q;
   assign data_out  = dout_q;

   // Select coefficient a_k and history y[n-k] for the current tap.
   always_comb begin
      coef = '0;
      hsel = '0;
      case (k_q)
         3'd1: begin coef = A1; hsel = hist_q[1]; end
         3'd2: begin coef = A2; hsel = hist_q[2]; end
         3'd3: begin coef = A3; hsel = hist_q[3]; end
         3'd4: begin coef = A4; hsel = hist_q[4]; end
         3'd5: begin coef = A5; hsel = hist_q[5]; end
         3'd6: begin coef = A6; hsel = hist_q[6]; end
         3'd7: begin coef = A7; hsel = hist_q[7]; end
         default: begin coef = '0; hsel = '0; end
      endcase
   end

   assign prod     = coef * hsel;
   assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
   assign load     = {{(ACC_W-31){data_in[15]}}, data_in, 15'b0};

   // acc>>>15 fits Q1.15 only when bits above 30 all match the sign.
   assign hi  = acc_q[ACC_W-1:30];
   assign sat = (&hi || ~|hi) ? acc_q[30:15]
              : (acc_q[ACC_W-1] ? 16'h8000 : 16'h7FFF);

   // Next-state logic: load, multiply-accumulate, round/saturate, hand off.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      k_d     = k_q;
      dout_d  = dout_q;
      ov_d    = ov_q;
      for (int i = 1; i <= 7; i++) hist_d[i] = hist_q[i];
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               acc_d   = load;
               k_d     = 3'd1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q - prod_ext;
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) state_d = S_RESULT;
         end
         S_RESULT: begin
            dout_d    = sat;
            ov_d      = 1'b1;
            hist_d[1] = sat;
            for (int i = 2; i <= 7; i++) hist_d[i] = hist_q[i-1];
            state_d   = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset also clears the feedback history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         dout_q  <= '0;
         ov_q    <= 1'b0;
         for (int i = 1; i <= 7; i++) hist_q[i] <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         dout_q  <= dout_d;
         ov_q    <= ov_d;
         for (int i = 1; i <= 7; i++) hist_q[i] <= hist_d[i];
      end
   end

endmodule

// File: tb/tb_iir_allpole_inverse.sv
// tb_iir_allpole_inverse: directed and random checks of the
// all-pole inverse filter against a plain-arithmetic model.
module tb_iir_allpole_inverse;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, in_valid, out_ready;
   logic [15:0] data_in;
   logic        in_ready, out_valid, busy;
   logic [15:0] data_out;

   logic        reset2, in_valid2, out_ready2;
   logic [15:0] data_in2;
   logic        in_ready2, out_valid2, busy2;
   logic [15:0] data_out2;

   int errors = 0;
   int checks = 0;

   longint hist [2][8];
   longint coef [2][8];

   iir_allpole_inverse dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .data_in  (data_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .data_out (data_out),
      .busy     (busy)
   );

   iir_allpole_inverse #(.A2(16'sh2000)) dut2 (
      .clk      (clk),
      .reset    (reset2),
      .in_valid (in_valid2),
      .in_ready (in_ready2),
      .data_in  (data_in2),
      .out_valid(out_valid2),
      .out_ready(out_ready2),
      .data_out (data_out2),
      .busy     (busy2)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic mreset(input int w);
      for (int k = 0; k < 8; k++) hist[w][k] = 0;
   endtask

   // y = x - sum a_k*y[n-k], floored to Q1.15 and clipped.
   task automatic model(input int w, input logic [15:0] x,
                        output logic [15:0] y);
      longint acc, r;
      acc = longint'($signed(x)) * 32768;
      for (int k = 1; k <= 7; k++) acc -= coef[w][k] * hist[w][k];
      r = acc >>> 15;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      for (int k = 7; k >= 2; k--) hist[w][k] = hist[w][k-1];
      hist[w][1] = r;
      y = r[15:0];
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready_low", {15'b0, in_ready}, 16'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
      chk("rst_data_out", data_out, 16'h0000);
      chk("rst_busy", {15'b0, busy}, 16'd0);
      chk("rst_in_ready", {15'b0, in_ready}, 16'd1);
      mreset(0);
   endtask

   // Send one sample on dut, check 8-edge latency, then the result.
   task automatic run1(input logic [15:0] x, input logic [15:0] exp,
                       input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy"}, {15'b0, in_ready}, 16'd1);
      in_valid = 1'b1;
      data_in  = x;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      data_in  = 16'hDEAD;
      chk({tag, "_busy"}, {15'b0, busy}, 16'd1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk({tag, "_ov"}, {15'b0, out_valid}, (c == 8) ? 16'd1 : 16'd0);
         chk({tag, "_nrdy"}, {15'b0, in_ready}, 16'd0);
      end
      chk(tag, data_out, exp);
   endtask

   task automatic run2(input logic [15:0] x, input logic [15:0] exp);
      int n;
      logic [15:0] y;
      n = 0;
      while (in_ready2 !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("r2_rdy", {15'b0, in_ready2}, 16'd1);
      in_valid2 = 1'b1;
      data_in2  = x;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      data_in2  = $urandom;
      n = 0;
      while (out_valid2 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("r2_ov", {15'b0, out_valid2}, 16'd1);
      y = data_out2;
      chk("r2_data", y, exp);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("r2_hold", data_out2, exp);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
   endtask

   initial begin
      logic [15:0] x, e, held;
      for (int w = 0; w < 2; w++)
         for (int k = 0; k < 8; k++) coef[w][k] = 0;
      coef[0][1] = -16384;
      coef[1][1] = -16384;
      coef[1][2] = 8192;
      mreset(0);
      mreset(1);

      reset = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;  data_in = '0;
      reset2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; data_in2 = '0;

      do_reset();

      // impulse with back-pressure on the first output
      out_ready = 1'b0;
      run1(16'h4000, 16'h4000, "imp0");
      held = data_out;
      in_valid = 1'b1;
      data_in  = 16'h0000;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("bp_ov", {15'b0, out_valid}, 16'd1);
         chk("bp_data", data_out, 16'h4000);
         chk("bp_nrdy", {15'b0, in_ready}, 16'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_ov", {15'b0, out_valid}, 16'd0);
      chk("bp_rel_rdy", {15'b0, in_ready}, 16'd1);
      chk("bp_keep", data_out, held);
      run1(16'h0000, 16'h2000, "imp1");
      repeat (5) @(negedge clk);
      run1(16'h0000, 16'h1000, "imp2");
      run1(16'h0000, 16'h0800, "imp3");
      run1(16'h0000, 16'h0400, "imp4");

      // floor rounding, both signs
      do_reset();
      run1(16'h0001, 16'h0001, "flp0");
      run1(16'h0000, 16'h0000, "flp1");
      do_reset();
      run1(16'hFFFF, 16'hFFFF, "fln0");
      run1(16'h0000, 16'hFFFF, "fln1");

      // saturation at both rails
      do_reset();
      for (int i = 0; i < 3; i++) run1(16'h7FFF, 16'h7FFF, "satp");
      do_reset();
      for (int i = 0; i < 3; i++) run1(16'h8000, 16'h8000, "satn");

      // reset during MAC clears history
      do_reset();
      run1(16'h4000, 16'h4000, "pre");
      @(negedge clk);
      chk("mid_rdy", {15'b0, in_ready}, 16'd1);
      in_valid = 1'b1;
      data_in  = 16'h4000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_busy", {15'b0, busy}, 16'd0);
      chk("mid_ov", {15'b0, out_valid}, 16'd0);
      chk("mid_nrdy", {15'b0, in_ready}, 16'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rel_rdy", {15'b0, in_ready}, 16'd1);
      run1(16'h4000, 16'h4000, "post_rst");

      // random samples on the default build
      do_reset();
      for (int i = 0; i < 40; i++) begin
         x = 16'($urandom);
         model(0, x, e);
         run1(x, e, "rnd1");
      end

      // random samples on the two-tap build
      @(negedge clk);
      reset2 = 1'b1;
      mreset(1);
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         x = 16'($urandom);
         model(1, x, e);
         run2(x, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iir_allpole_inverse.md
Name: iir_allpole_inverse

Overview:
Sequential all-pole IIR filter, 1/A(z), that undoes an FIR shaping stage in the same Q1.15 datapath. It computes y[n] = x[n] - sum_{k=1..7} a_k*y[n-k], with a0 fixed at 1. A single multiplier is time-shared over the 7 feedback taps, one tap per clock. Samples move through valid/ready handshakes, so it can sit directly behind an FIR output stage or a sample source.

Parameters:
A1, 16'shC000, feedback coef a1, Q1.15 (-0.5)
A2..A7, 16'sh0000 each, feedback coefs a2..a7, Q1.15
ACC_W, 40, accumulator width in bits (Q10.30), min 36

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  data_in is valid
in_ready  output  1  block can accept a sample
data_in  input  16  signed Q1.15 sample x[n]
out_valid  output  1  data_out holds y[n]
out_ready  input  1  downstream accepts data_out
data_out  output  16  signed Q1.15 result y[n], saturated
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; history y[n-1..n-7]=0; acc=0; tap counter=0; data_out=0; out_valid=0; in_ready=0 while asserted; busy=0.
- IDLE: in_ready=1.
  - in_valid&&in_ready loads acc = sign-extend(data_in) <<< 15.
  - Tap counter k=1, go to MAC.
- MAC: in_ready=0. Each cycle: acc <= acc - a_k*y[n-k] (full 32-bit signed product, sign-extended to ACC_W); k++.
  - After k=7 (7 cycles), go to RESULT.
- RESULT (1 cycle):
  - r = acc >>> 15 (arithmetic, floor rounding).
  - Saturate: r>32767 -> 16'h7FFF; r<-32768 -> 16'h8000.
  - data_out <= sat(r); out_valid <= 1.
  - History shifts: y[n-7..n-2] <= y[n-6..n-1]; y[n-1] <= sat(r). The feedback path uses the saturated value.
  - Go to OUT.
- OUT: out_valid=1; data_out held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- Latency: acceptance edge at cycle 0 -> out_valid high after edge 8. Best-case throughput is 1 sample per 10 cycles with out_ready tied to 1.
- in_valid asserted outside IDLE is ignored; the source must hold in_valid and data_in until in_ready.
- in_valid low in IDLE: no state change; history is retained indefinitely.
- data_out keeps its last value after the handshake (out_valid=0); only out_valid qualifies it.
- Reset asserted mid-MAC or mid-OUT aborts immediately and clears history. The first sample after reset sees zero history.
- Coefficients are compile-time only. The accumulator must not wrap for any inputs: |x|+7*|a||y| < 2^(ACC_W-31).

Test Plan:
- Reset values: hold reset=0 for 3 cycles, release -> out_valid=0, data_out=0, busy=0, in_ready=1 on the next edge.
- Impulse, defaults, out_ready=1: x = 0x4000 then 0x0000 x4 -> y = 0x4000, 0x2000, 0x1000, 0x0800, 0x0400. Each out_valid rises 8 cycles after its accept; in_ready=0 during MAC/RESULT/OUT.
- Floor rounding: x = 0x0001, 0x0000 -> y = 0x0001, 0x0000. After reset, x = 0xFFFF, 0x0000 -> y = 0xFFFF, 0xFFFF (-0.5 LSB floors to -1).
- Saturation both rails: constant x = 0x7FFF x3 -> y = 0x7FFF, 0x7FFF, 0x7FFF. After reset, constant x = 0x8000 x3 -> y = 0x8000 each.
- Back-pressure: out_ready=0 for 20 cycles after out_valid -> data_out and out_valid stable, in_ready=0, second sample not accepted. Then out_ready=1 for 1 cycle -> IDLE, next sample accepted, history continuity matches the impulse sequence.
- Reset mid-operation: accept 0x4000, assert reset during MAC cycle 4, release, send 0x4000 -> out 0x4000 (history cleared, not 0x6000). A multi-tap build (A2=16'h2000, others 0) matches a bit-exact software model over 200 random samples.
